prod_accum: RTL and testbench
=============================

Name: prod_accum

Overview:
- Consumes the signed product stream from the multiplier stage and sums a fixed group of `n_terms` products (one kernel window / dot product).
- Rescales each completed sum by an arithmetic right shift and saturates it to the activation width.
- Presents the result on a valid/ready output register to the next layer stage.
- Sits directly downstream of the multiplier; one instance per multiplier lane.

Parameters:
- prod_size, 18, width of the signed product input (multiplier `a_size + b_size`)
- n_terms, 9, products per result; legal range ≥1
- acc_size, 24, internal accumulator width; must be ≥ prod_size + clog2(n_terms)
- out_size, 16, width of the signed result
- shift, 2, arithmetic right shift applied to the final sum; legal range 0..acc_size-1
- sat_en, 1, 1 = saturate to out_size; 0 = truncate (keep the low out_size bits)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- prod  in  prod_size  signed product from the multiplier
- prod_v  in  1  product valid
- prod_ready  out  1  stage can accept a product this cycle
- clear  in  1  synchronous flush of the partial sum
- out  out  out_size  signed rescaled result
- out_v  out  1  result valid
- out_ready  in  1  downstream accepts the result
- ovf  out  1  result was saturated (qualified by out_v)

Behaviour:
- Reset (rst_n=0, asynchronous): acc=0, count=0, out=0, out_v=0, ovf=0. Applies immediately, including mid-group; the partial sum is discarded.
- Accept condition: acc_fire = prod_v && prod_ready.
- prod_ready = !clear && (count != n_terms-1 || !out_v || out_ready).
  - Partial terms always accept, so accumulation continues while the output stalls.
  - Only the final term of a group waits for the output register to free.
- Non-final accept (count < n_terms-1): acc += sign-extended prod; count++. acc wraps modulo 2^acc_size; no saturation inside the accumulator.
- Final accept (count == n_terms-1):
  - sum = acc + prod at acc_size width.
  - s = sum >>> shift (floor toward -inf).
  - sat_en=1: if s > 2^(out_size-1)-1, out = that value and ovf=1; if s < -2^(out_size-1), out = that value and ovf=1; otherwise out = s and ovf=0.
  - sat_en=0: out = s[out_size-1:0], ovf=0.
  - Register out and ovf, set out_v=1, clear acc to 0 and count to 0.
  - Latency: out_v asserts the cycle after the final term is accepted.
- Output handshake:
  - out_v && out_ready at a clock edge → out_v drops, unless a new final term is accepted the same cycle; then out_v stays 1 with the new value, giving one result per n_terms cycles sustained.
  - While out_v=1 and out_ready=0, out and ovf are held stable.
- n_terms=1: every accept is a final term; count stays 0.
- clear=1: next edge sets acc=0 and count=0. prod_ready is low, so no product is taken that cycle. Clear does not touch out, out_v or ovf; a pending result is still delivered.
- out and ovf change only when a result is loaded or on reset.

Test Plan:
- Defaults; products 1..9 with prod_v held high → 9 accepts in 9 cycles; one cycle later out=11 (45>>>2), out_v=1, ovf=0.
- Nine products of -5 → out=-12 (-45>>>2, floor), ovf=0.
- Nine products of 131071 → sum 1179639, shifted 294909 → out=32767, ovf=1. Nine products of -131072 → out=-32768, ovf=1.
- Backpressure:
  - Group 1 = nine 1s, with out_ready held 0.
  - Group 2 = nine 2s: first 8 accepted; at the 9th, prod_ready=0 and out=2 held stable.
  - Raise out_ready → group 1 result (2) consumed, 9th term accepted the same cycle, next cycle out=4 (18>>>2), out_v stays 1.
- Four products of 100, pulse clear (prod_v=1 that cycle → prod_ready=0, nothing accepted), then nine 1s → out=2, not 102.
- Five products of 7, then rst_n low for a non-edge-aligned interval → out_v, out, ovf go 0 immediately. After release, nine 4s → out=9 (36>>>2).

Source files
------------

// File: rtl/prod_accum_if.sv
// Product-in / result-out handshake bundle between the multiplier lane and the
// accumulator stage.
interface prod_accum_if #(
    parameter int prod_size = 18,
    parameter int out_size  = 16
);
    logic signed [prod_size-1:0] prod;
    logic                        prod_v;
    logic                        prod_ready;
    logic                        clear;
    logic signed [out_size-1:0]  out;
    logic                        out_v;
    logic                        out_ready;
    logic                        ovf;

    modport master (
        output prod, prod_v, clear, out_ready,
        input  prod_ready, out, out_v, ovf
    );

    modport slave (
        input  prod, prod_v, clear, out_ready,
        output prod_ready, out, out_v, ovf
    );
endinterface

// File: rtl/prod_accum.sv
// Sums groups of n_terms signed products, rescales by an arithmetic right shift,
// saturates or truncates to out_size and presents the result on a valid/ready register.
module prod_accum #(
    parameter int prod_size = 18,
    parameter int n_terms   = 9,
    parameter int acc_size  = 24,
    parameter int out_size  = 16,
    parameter int shift     = 2,
    parameter bit sat_en    = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    prod_accum_if.slave    bus
);
    localparam int cnt_w = (n_terms > 1) ? $clog2(n_terms) : 1;
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(n_terms - 1);
    // Wide enough to hold the shifted sum and compare it against out_size limits.
    localparam int ext_w = ((acc_size > out_size) ? acc_size : out_size) + 1;

    logic signed [acc_size-1:0] acc_r;
    logic        [cnt_w-1:0]    count_r;
    logic signed [out_size-1:0] out_r;
    logic                       out_v_r;
    logic                       ovf_r;

    logic signed [acc_size-1:0] prod_ext_s;
    logic signed [acc_size-1:0] sum_s;
    logic signed [acc_size-1:0] shifted_s;
    logic signed [ext_w-1:0]    shifted_ext_s;
    logic        [out_size:0]   res_s;
    logic                       final_s;
    logic                       ready_s;
    logic                       fire_s;
    logic                       consume_s;

    // Returns {ovf, value}: clamps to the out_size signed range, or keeps the low bits.
    function automatic logic [out_size:0] sat_fn(input logic signed [ext_w-1:0] v);
        logic [ext_w-out_size:0] top_s;
        top_s = v[ext_w-1:out_size-1];
        if (!sat_en) begin
            return {1'b0, v[out_size-1:0]};
        end else if ((top_s == {(ext_w-out_size+1){1'b0}}) ||
                     (top_s == {(ext_w-out_size+1){1'b1}})) begin
            return {1'b0, v[out_size-1:0]};
        end else if (v[ext_w-1]) begin
            return {1'b1, 1'b1, {(out_size-1){1'b0}}};
        end else begin
            return {1'b1, 1'b0, {(out_size-1){1'b1}}};
        end
    endfunction

    // Datapath for the next accumulation and the rescaled result of a completed group.
    always_comb begin
        prod_ext_s    = acc_size'(bus.prod);
        sum_s         = acc_r + prod_ext_s;
        shifted_s     = sum_s >>> shift;
        shifted_ext_s = ext_w'(shifted_s);
        res_s         = sat_fn(shifted_ext_s);
    end

    // Handshake: only the last term of a group has to wait for the output register.
    always_comb begin
        final_s   = (count_r == last_cnt);
        ready_s   = !bus.clear && (!final_s || !out_v_r || bus.out_ready);
        fire_s    = bus.prod_v && ready_s;
        consume_s = out_v_r && bus.out_ready;
    end

    // Accumulator, term counter and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r   <= {acc_size{1'b0}};
            count_r <= {cnt_w{1'b0}};
            out_r   <= {out_size{1'b0}};
            out_v_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            if (bus.clear) begin
                acc_r   <= {acc_size{1'b0}};
                count_r <= {cnt_w{1'b0}};
            end else if (fire_s && final_s) begin
                acc_r   <= {acc_size{1'b0}};
                count_r <= {cnt_w{1'b0}};
            end else if (fire_s) begin
                acc_r   <= sum_s;
                count_r <= count_r + cnt_w'(1);
            end else begin
                acc_r   <= acc_r;
                count_r <= count_r;
            end

            // A result loaded on the same edge it is consumed keeps out_v high.
            if (fire_s && final_s) begin
                out_r   <= res_s[out_size-1:0];
                ovf_r   <= res_s[out_size];
                out_v_r <= 1'b1;
            end else if (consume_s) begin
                out_r   <= out_r;
                ovf_r   <= ovf_r;
                out_v_r <= 1'b0;
            end else begin
                out_r   <= out_r;
                ovf_r   <= ovf_r;
                out_v_r <= out_v_r;
            end
        end
    end

    assign bus.prod_ready = ready_s;
    assign bus.out        = out_r;
    assign bus.out_v      = out_v_r;
    assign bus.ovf        = ovf_r;
endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: a group-level reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_prod_accum;
    localparam int PS = 18;
    localparam int NT = 9;
    localparam int AS = 24;
    localparam int OS = 16;
    localparam int SH = 2;
    localparam bit SE = 1'b1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prod_accum_if #(.prod_size(PS), .out_size(OS)) bus();

    prod_accum #(
        .prod_size(PS), .n_terms(NT), .acc_size(AS),
        .out_size(OS), .shift(SH), .sat_en(SE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: products of the current group, plus the output register.
    longint m_sum = 0;
    int     m_cnt = 0;
    bit     m_v   = 1'b0;
    bit     m_ovf = 1'b0;
    longint m_out = 0;

    function automatic void rescale(input longint total, output longint o, output bit f);
        longint w, d, q, lim_hi, lim_lo;
        w = total & ((longint'(1) << AS) - 1);
        if (w >= (longint'(1) << (AS - 1))) w = w - (longint'(1) << AS);
        d = longint'(1) << SH;
        q = w / d;
        if ((w % d) != 0 && w < 0) q = q - 1;
        lim_hi = (longint'(1) << (OS - 1)) - 1;
        lim_lo = -(longint'(1) << (OS - 1));
        f = 1'b0;
        o = q;
        if (SE) begin
            if (q > lim_hi) begin o = lim_hi; f = 1'b1; end
            else if (q < lim_lo) begin o = lim_lo; f = 1'b1; end
        end else begin
            o = q & ((longint'(1) << OS) - 1);
            if (o > lim_hi) o = o - (longint'(1) << OS);
        end
    endfunction

    function automatic bit model_ready();
        return !bus.clear && ((m_cnt != NT - 1) || !m_v || bus.out_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit fire, fin;
        if (!rst_n) begin
            m_sum = 0; m_cnt = 0; m_v = 1'b0; m_ovf = 1'b0; m_out = 0;
        end else begin
            fire = bus.prod_v && model_ready();
            fin  = 1'b0;
            if (bus.clear) begin
                m_sum = 0; m_cnt = 0;
            end else if (fire) begin
                m_sum = m_sum + longint'(bus.prod);
                m_cnt = m_cnt + 1;
                if (m_cnt == NT) begin
                    rescale(m_sum, m_out, m_ovf);
                    m_v = 1'b1; m_sum = 0; m_cnt = 0; fin = 1'b1;
                end
            end
            if (!fin && m_v && bus.out_ready) m_v = 1'b0;
        end
    end

    // Cycle-by-cycle comparison against the model on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_prod_ready", longint'(bus.prod_ready), longint'(model_ready()));
            chk("model_out_v", longint'(bus.out_v), longint'(m_v));
            chk("model_out", longint'(bus.out), m_out);
            chk("model_ovf", longint'(bus.ovf), longint'(m_ovf));
        end
    end

    task automatic push(input logic signed [PS-1:0] v);
        int k;
        bus.prod   = v;
        bus.prod_v = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.prod_ready) break;
        end
        if (k == 50) chk("push_timeout", 0, 1);
        @(posedge clk); #2;
        bus.prod_v = 1'b0;
    endtask

    task automatic push_n(input logic signed [PS-1:0] v, input int n);
        for (int i = 0; i < n; i++) push(v);
    endtask

    task automatic expect_res(input string name, input longint o, input longint f);
        @(negedge clk);
        chk({name, "_out_v"}, longint'(bus.out_v), 1);
        chk({name, "_out"}, longint'(bus.out), o);
        chk({name, "_ovf"}, longint'(bus.ovf), f);
        @(posedge clk); #2;
    endtask

    initial begin
        time t0;
        bus.prod = '0; bus.prod_v = 1'b0; bus.clear = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_v", longint'(bus.out_v), 0);
        chk("rst_out", longint'(bus.out), 0);
        chk("rst_ovf", longint'(bus.ovf), 0);
        chk("rst_prod_ready", longint'(bus.prod_ready), 1);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #2;

        // 1..9 with prod_v held high: 45 >>> 2 = 11
        t0 = $time;
        for (int i = 1; i <= 9; i++) push(PS'(i));
        chk("seq_cycles", longint'(($time - t0) / 10), 9);
        expect_res("seq", 11, 0);

        // -45 >>> 2 floors to -12
        push_n(-18'sd5, 9);
        expect_res("neg", -12, 0);

        // Positive and negative saturation
        push_n(18'sd131071, 9);
        expect_res("sat_hi", 32767, 1);
        push_n(-18'sd131072, 9);
        expect_res("sat_lo", -32768, 1);

        // Backpressure: group 1 held, last term of group 2 waits
        bus.out_ready = 1'b0;
        push_n(18'sd1, 9);
        expect_res("bp_g1", 2, 0);
        push_n(18'sd2, 8);
        bus.prod = 18'sd2; bus.prod_v = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready_low", longint'(bus.prod_ready), 0);
            chk("bp_hold_out", longint'(bus.out), 2);
            chk("bp_hold_v", longint'(bus.out_v), 1);
        end
        @(posedge clk); #2;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_high", longint'(bus.prod_ready), 1);
        @(posedge clk); #2;
        bus.prod_v = 1'b0;
        expect_res("bp_g2", 4, 0);

        // Clear flushes a partial group and blocks the product offered with it
        push_n(18'sd100, 4);
        bus.prod = 18'sd5; bus.prod_v = 1'b1; bus.clear = 1'b1;
        @(negedge clk);
        chk("clr_ready", longint'(bus.prod_ready), 0);
        @(posedge clk); #2;
        bus.clear = 1'b0; bus.prod_v = 1'b0;
        push_n(18'sd1, 9);
        expect_res("clr", 2, 0);

        // Asynchronous reset mid-group with a pending result
        bus.out_ready = 1'b0;
        push_n(18'sd8, 9);
        expect_res("pre_rst", 18, 0);
        push_n(18'sd7, 5);
        #4 rst_n = 1'b0;
        #1;
        chk("arst_out_v", longint'(bus.out_v), 0);
        chk("arst_out", longint'(bus.out), 0);
        chk("arst_ovf", longint'(bus.ovf), 0);
        #7 rst_n = 1'b1;
        @(posedge clk); #2;
        bus.out_ready = 1'b1;
        push_n(18'sd4, 9);
        expect_res("post_rst", 9, 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
